// File: rtl/psg_mix_ctrl.sv
// PSG mixer register file and shared volume-envelope controller (tone A, tone B, noise).
// Build option: PSG_MIX_CTRL_ENVELOPE_EN enables envelope, prescaler, regs 4-6 and env_sel bits.

module psg_mix_chan (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_vol_wr,
  input  logic [4:0] i_vol_data,
  input  logic       i_en_wr,
  input  logic       i_en_data,
  input  logic       i_env_use,
  input  logic [3:0] i_env_nxt,
  output logic [3:0] o_volume,
  output logic       o_enable
);
  logic [3:0] r_vol;
  logic       r_sel;
  logic [3:0] w_vol_nxt;
  logic       w_sel_nxt;
  logic       w_en_nxt;

  always_comb begin
    w_vol_nxt = i_vol_wr ? i_vol_data[3:0] : r_vol;
    w_sel_nxt = i_vol_wr ? i_vol_data[4]   : r_sel;
    w_en_nxt  = i_en_wr  ? i_en_data       : o_enable;
  end

  // Outputs are built from next-state values so they move on the same edge as the registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vol    <= '0;
      r_sel    <= 1'b0;
      o_enable <= 1'b0;
      o_volume <= '0;
    end else begin
      r_vol    <= w_vol_nxt;
      r_sel    <= w_sel_nxt;
      o_enable <= w_en_nxt;
      o_volume <= (i_env_use && w_sel_nxt) ? i_env_nxt : w_vol_nxt;
    end
  end
endmodule

module psg_mix_ctrl #(
  parameter int PRESCALE_W  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_strobe,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  output logic [3:0] volume_a,
  output logic [3:0] volume_b,
  output logic [3:0] volume_noise,
  output logic       enable_a,
  output logic       enable_b,
  output logic       enable_noise,
  output logic [3:0] env_level,
  output logic       env_active
);
  localparam int NUM_CH = 3;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_qq;
  logic                   w_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync    <= '0;
      r_sync_qq <= 1'b0;
      wr_ack    <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], wr_strobe};
      r_sync_qq <= r_sync[SYNC_STAGES-1];
      wr_ack    <= w_wr;
    end
  end

  assign w_wr = r_sync[SYNC_STAGES-1] & ~r_sync_qq;

  logic [3:0] w_env_nxt;
  logic       w_env_use;

`ifdef PSG_MIX_CTRL_ENVELOPE_EN
  typedef enum logic {S_HOLD, S_RUN} env_state_t;
  localparam int HI_W = PRESCALE_W - 8;

  env_state_t             r_state, w_state_nxt;
  logic [PRESCALE_W-1:0]  r_period, w_period_nxt;
  logic [PRESCALE_W-1:0]  r_cnt, w_cnt_nxt;
  logic                   r_attack, r_cont, r_alt, r_dir;
  logic                   w_attack_nxt, w_cont_nxt, w_alt_nxt, w_dir_nxt;
  logic                   w_shape_wr, w_tick, w_end;

  assign w_env_use  = 1'b1;
  assign w_shape_wr = w_wr && (wr_addr == 3'd6);
  assign w_tick     = (r_state == S_RUN) && (r_cnt >= r_period);
  assign w_end      = r_dir ? (env_level == 4'd15) : (env_level == 4'd0);

  always_comb begin
    w_period_nxt = r_period;
    w_attack_nxt = r_attack;
    w_cont_nxt   = r_cont;
    w_alt_nxt    = r_alt;
    w_state_nxt  = r_state;
    w_dir_nxt    = r_dir;
    w_env_nxt    = env_level;
    w_cnt_nxt    = r_cnt;
    if (w_wr && (wr_addr == 3'd4)) w_period_nxt[7:0] = wr_data;
    if (w_wr && (wr_addr == 3'd5)) w_period_nxt[PRESCALE_W-1:8] = HI_W'(wr_data);
    // A shape write restarts the envelope and swallows any tick landing on the same edge.
    if (w_shape_wr) begin
      w_attack_nxt = wr_data[0];
      w_cont_nxt   = wr_data[1];
      w_alt_nxt    = wr_data[2];
      w_dir_nxt    = wr_data[0];
      w_env_nxt    = wr_data[0] ? 4'd0 : 4'd15;
      w_cnt_nxt    = '0;
      w_state_nxt  = S_RUN;
    end else if (r_state == S_RUN) begin
      if (w_tick) begin
        w_cnt_nxt = '0;
        if (!w_end) begin
          w_env_nxt = r_dir ? env_level + 4'd1 : env_level - 4'd1;
        end else if (!r_cont) begin
          w_env_nxt   = 4'd0;
          w_state_nxt = S_HOLD;
        end else if (r_alt) begin
          w_dir_nxt = ~r_dir;
        end else begin
          w_env_nxt = r_dir ? 4'd0 : 4'd15;
        end
      end else begin
        w_cnt_nxt = r_cnt + {{(PRESCALE_W-1){1'b0}}, 1'b1};
      end
    end else begin
      w_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_HOLD;
      r_period   <= '0;
      r_cnt      <= '0;
      r_attack   <= 1'b0;
      r_cont     <= 1'b0;
      r_alt      <= 1'b0;
      r_dir      <= 1'b0;
      env_level  <= '0;
      env_active <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_period   <= w_period_nxt;
      r_cnt      <= w_cnt_nxt;
      r_attack   <= w_attack_nxt;
      r_cont     <= w_cont_nxt;
      r_alt      <= w_alt_nxt;
      r_dir      <= w_dir_nxt;
      env_level  <= w_env_nxt;
      env_active <= (w_state_nxt == S_RUN);
    end
  end

  logic w_unused;
  assign w_unused = r_attack;
`else
  logic [PRESCALE_W-1:0] w_unused_pw;
  logic                  w_unused;

  assign w_env_use   = 1'b0;
  assign w_env_nxt   = '0;
  assign env_level   = '0;
  assign env_active  = 1'b0;
  assign w_unused_pw = '0;
  assign w_unused    = &{1'b0, wr_data[7:5], w_unused_pw};
`endif

  logic [NUM_CH-1:0][3:0] w_volume;
  logic [NUM_CH-1:0]      w_enable;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
    psg_mix_chan u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_vol_wr   (w_wr && (wr_addr == 3'(ch))),
      .i_vol_data (wr_data[4:0]),
      .i_en_wr    (w_wr && (wr_addr == 3'd3)),
      .i_en_data  (wr_data[ch]),
      .i_env_use  (w_env_use),
      .i_env_nxt  (w_env_nxt),
      .o_volume   (w_volume[ch]),
      .o_enable   (w_enable[ch])
    );
  end

  assign volume_a     = w_volume[0];
  assign volume_b     = w_volume[1];
  assign volume_noise = w_volume[2];
  assign enable_a     = w_enable[0];
  assign enable_b     = w_enable[1];
  assign enable_noise = w_enable[2];
endmodule

// File: tb/tb_psg_mix_ctrl.sv
// Self-checking bench for psg_mix_ctrl: directed register/envelope steps plus randomized traffic.
// The envelope reference is a closed-form function of elapsed ticks since the last shape write.

module tb_psg_mix_ctrl;
`ifdef PSG_MIX_CTRL_ENVELOPE_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_strobe = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       wr_ack;
  logic [3:0] volume_a, volume_b, volume_noise, env_level;
  logic       enable_a, enable_b, enable_noise, env_active;

  psg_mix_ctrl dut (
    .clk(clk), .rst_n(rst_n), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .volume_a(volume_a), .volume_b(volume_b), .volume_noise(volume_noise),
    .enable_a(enable_a), .enable_b(enable_b), .enable_noise(enable_noise),
    .env_level(env_level), .env_active(env_active)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  int m_vol[3];
  int m_sel[3];
  int m_en[3];
  int m_period;
  int m_shape;
  int w_cyc;
  bit env_on;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Level after t ticks: one-shot ramp, sawtooth (period 16) or triangle (period 32).
  function automatic int env_lvl(input int shape, input int t);
    int ph, tri_v;
    if (!shape[1]) return (t >= 16) ? 0 : (shape[0] ? t : 15 - t);
    if (!shape[2]) begin
      ph = t % 16;
      return shape[0] ? ph : 15 - ph;
    end
    ph = t % 32;
    tri_v = (ph < 16) ? ph : 31 - ph;
    return shape[0] ? tri_v : 15 - tri_v;
  endfunction

  function automatic int exp_level();
    if (!env_on) return 0;
    return env_lvl(m_shape, (cyc - w_cyc) / (m_period + 1));
  endfunction

  function automatic int exp_active();
    if (!env_on) return 0;
    return (m_shape[1] || ((cyc - w_cyc) / (m_period + 1)) < 16) ? 1 : 0;
  endfunction

  function automatic int exp_vol(input int ch, input int lvl);
    return (EN && m_sel[ch] != 0) ? lvl : m_vol[ch];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_vol[i] = 0; m_sel[i] = 0; m_en[i] = 0;
    end
    m_period = 0; m_shape = 0; w_cyc = 0; env_on = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    int lvl;
    lvl = exp_level();
    chk({tag, ".vol_a"}, volume_a, exp_vol(0, lvl));
    chk({tag, ".vol_b"}, volume_b, exp_vol(1, lvl));
    chk({tag, ".vol_n"}, volume_noise, exp_vol(2, lvl));
    chk({tag, ".en_a"}, enable_a, m_en[0]);
    chk({tag, ".en_b"}, enable_b, m_en[1]);
    chk({tag, ".en_n"}, enable_noise, m_en[2]);
    chk({tag, ".env_level"}, env_level, lvl);
    chk({tag, ".env_active"}, env_active, exp_active());
  endtask

  task automatic run_check(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk({tag, ".ack_idle"}, wr_ack, 0);
      check_outputs(tag);
    end
  endtask

  task automatic model_write(input int a, input logic [7:0] d);
    case (a)
      0, 1, 2: begin m_vol[a] = d[3:0]; m_sel[a] = d[4]; end
      3: begin m_en[0] = d[0]; m_en[1] = d[1]; m_en[2] = d[2]; end
      4: if (EN) m_period = (m_period & 32'hFF00) | d;
      5: if (EN) m_period = (m_period & 32'h00FF) | (int'(d) << 8);
      6: if (EN) begin m_shape = d[2:0]; env_on = 1'b1; w_cyc = cyc; end
      default: ;
    endcase
  endtask

  // Strobe sampled on the first edge; the write must land on the third.
  task automatic do_write(input int a, input logic [7:0] d);
    @(negedge clk);
    wr_addr = 3'(a); wr_data = d; wr_strobe = 1'b1;
    @(posedge clk); #1;
    chk("ack_lat1", wr_ack, 0);
    @(posedge clk); #1;
    chk("ack_lat2", wr_ack, 0);
    @(posedge clk); #1;
    model_write(a, d);
    chk("ack_pulse", wr_ack, 1);
    check_outputs("write");
    @(negedge clk);
    wr_strobe = 1'b0;
    run_check(2, "post_write");
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int acks, a, p;
    logic [7:0] d;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk("reset.ack", wr_ack, 0);
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_check(2, "reset_rel");

    do_write(0, 8'h0A);
    do_write(3, 8'h01);
    chk("dir.vol_a", volume_a, 10);
    chk("dir.en_a", enable_a, 1);

    // Strobe held for 20 clocks must produce exactly one write.
    @(negedge clk);
    wr_addr = 3'd1; wr_data = 8'h05; wr_strobe = 1'b1;
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (wr_ack) acks++;
    end
    chk("hold.acks", 16'(acks), 1);
    model_write(1, 8'h05);
    chk("hold.vol_b", volume_b, 5);
    check_outputs("hold");
    @(negedge clk);
    wr_strobe = 1'b0;
    run_check(2, "hold_rel");

    // Random register traffic while the envelope is idle (level 0).
    for (int i = 0; i < 12; i++) begin
      a = $urandom_range(0, 7);
      if (EN && a == 6) a = 7;
      d = 8'($urandom_range(0, 255));
      do_write(a, d);
    end

`ifdef PSG_MIX_CTRL_ENVELOPE_EN
    reset_dut();
    do_write(4, 8'h00);
    do_write(0, 8'h10);
    do_write(6, 8'h01);
    run_check(20, "ramp_up");

    reset_dut();
    do_write(4, 8'h03);
    do_write(0, 8'h10);
    do_write(6, 8'h06);
    run_check(140, "triangle");

    // Restart write landing exactly on a tick edge (k = 8, period 3).
    reset_dut();
    do_write(4, 8'h03);
    do_write(0, 8'h10);
    do_write(6, 8'h00);
    run_check(3, "pre_tick");
    do_write(6, 8'h00);
    chk("tick_restart.level", env_level, 15);
    run_check(8, "tick_restart");

    for (int it = 0; it < 4; it++) begin
      reset_dut();
      p = $urandom_range(0, 3);
      do_write(4, 8'(p));
      do_write(0, 8'h10 | 8'($urandom_range(0, 15)));
      do_write(1, 8'($urandom_range(0, 15)));
      do_write(6, 8'($urandom_range(0, 7)));
      run_check(80, "rand_env");
    end

    do_write(6, 8'h02);
    run_check(5, "pre_reset");
`else
    do_write(0, 8'h1F);
    chk("noenv.vol_a", volume_a, 15);
    do_write(6, 8'h07);
    chk("noenv.active", env_active, 0);
    chk("noenv.level", env_level, 0);
`endif

    // Asynchronous reset asserted between edges clears everything at once.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst.ack", wr_ack, 0);
    check_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    run_check(3, "rst_release");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
